// File: rtl/cmp8_sort_ctrl_pkg.sv
// +-----------------------------------------------------------------+
// | cmp8_sort_pkg : shared types and helpers for cmp8_sort_ctrl      |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package cmp8_sort_pkg;

  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } sort_state_t;

  function automatic int n_compares(input int depth);
    return depth * (depth - 1) / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmp8_sort_ctrl_if.sv
// +-----------------------------------------------------------------+
// | cmp8_sort_ctrl_if : byte-in / byte-out valid-ready streams       |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

interface cmp8_sort_ctrl_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/cmp8.sv
// +-----------------------------------------------------------------+
// | cmp8 : unsigned 8-bit magnitude comparator                       |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module cmp8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       GREATER,
  output logic       LESSER
);
  assign GREATER = (a > b);
  assign LESSER  = (a < b);
endmodule

`default_nettype wire

// File: rtl/cmp8_sort_ctrl.sv
// +-----------------------------------------------------------------+
// | cmp8_sort_ctrl : load / bubble-sort / drain a block of bytes     |
// | using one shared cmp8. CMP8_SORT_EARLY_EXIT_EN enables early exit|
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module cmp8_sort_ctrl
  import cmp8_sort_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  cmp8_sort_ctrl_if.slave   bus
);

  localparam int              IW        = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0]   LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [IW-1:0]   LAST_PASS = IW'(DEPTH - 2);

  sort_state_t   state, state_nxt;
  logic [W-1:0]  mem [DEPTH];
  logic [IW-1:0] wr_idx, rd_idx, cmp_idx, pass_idx;
  logic [IW-1:0] cmp_idx_nxt;
  logic          gt, unused_lesser;
  logic          pass_end, sort_done;
  logic          in_fire, out_fire;

  assign cmp_idx_nxt = cmp_idx + IW'(1);
  assign in_fire     = bus.in_valid  && (state == LOAD);
  assign out_fire    = bus.out_ready && (state == DRAIN);
  // Pass p ends at index DEPTH-2-p; the last pass is a single compare.
  assign pass_end    = (cmp_idx == (LAST_PASS - pass_idx));

`ifdef CMP8_SORT_EARLY_EXIT_EN
  logic swapped;
  assign sort_done = pass_end && ((pass_idx == LAST_PASS) || !(swapped || gt));
`else
  assign sort_done = pass_end && (pass_idx == LAST_PASS);
`endif

  cmp8 u_cmp (
    .a       (mem[cmp_idx]),
    .b       (mem[cmp_idx_nxt]),
    .GREATER (gt),
    .LESSER  (unused_lesser)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && (wr_idx == LAST_IDX))   state_nxt = SORT;
      SORT:    if (sort_done)                         state_nxt = DRAIN;
      DRAIN:   if (out_fire && (rd_idx == LAST_IDX))  state_nxt = LOAD;
      default:                                        state_nxt = LOAD;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.busy      = 1'b0;
    case (state)
      LOAD:  bus.in_ready = 1'b1;
      SORT:  bus.busy     = 1'b1;
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.out_data  = mem[rd_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      cmp_idx  <= '0;
      pass_idx <= '0;
`ifdef CMP8_SORT_EARLY_EXIT_EN
      swapped  <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: if (in_fire) begin
          mem[wr_idx] <= bus.in_data;
          wr_idx      <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IW'(1);
        end
        SORT: begin
          // Strictly greater only, so equal keys keep their order.
          if (gt) begin
            mem[cmp_idx]     <= mem[cmp_idx_nxt];
            mem[cmp_idx_nxt] <= mem[cmp_idx];
          end
          if (sort_done) begin
            cmp_idx  <= '0;
            pass_idx <= '0;
          end else if (pass_end) begin
            cmp_idx  <= '0;
            pass_idx <= pass_idx + IW'(1);
          end else begin
            cmp_idx  <= cmp_idx_nxt;
          end
`ifdef CMP8_SORT_EARLY_EXIT_EN
          swapped <= pass_end ? 1'b0 : (swapped | gt);
`endif
        end
        DRAIN: if (out_fire) begin
          rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmp8_sort_ctrl.sv
// +-----------------------------------------------------------------+
// | tb_cmp8_sort_ctrl : directed self-checking bench for the sorter  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_cmp8_sort_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cmp8_sort_ctrl_if #(.W(8)) bus ();

  cmp8_sort_ctrl #(.DEPTH(4), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef CMP8_SORT_EARLY_EXIT_EN
  localparam int LEN_PRESORTED = 3;
  localparam int LEN_T6        = 5;
`else
  localparam int LEN_PRESORTED = 6;
  localparam int LEN_T6        = 6;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bytes are packed first-in in the top byte.
  task automatic run_block(input string name, input logic [31:0] din, input logic [31:0] dexp,
                           input int exp_len, input int stall, input bit aa, input bit probe_eq);
    int n;
    int idx;
    int st;
    int cyc;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq({name, "_in_ready_load"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = din[31-8*k -: 8];
    end
    @(negedge clk);
    bus.in_valid  = aa;
    bus.in_data   = aa ? 8'hAA : 8'h00;
    bus.out_ready = 1'b1;
    check_eq({name, "_in_ready_drop"}, 32'(bus.in_ready), 32'd0);
    n = 0;
    while (bus.busy && !bus.out_valid && n < 100) begin
      n++;
      if (probe_eq && n == 1)
        check_eq({name, "_eq_no_gt"}, 32'(dut.u_cmp.GREATER), 32'd0);
      if (aa) check_eq({name, "_sort_in_ready"}, 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    check_eq({name, "_sort_len"}, 32'(n), 32'(exp_len));
    idx = 0;
    st  = 0;
    cyc = 0;
    while (idx < 4 && cyc < 100) begin
      cyc++;
      bus.out_ready = !(idx == 1 && st < stall);
      if (!bus.out_ready) st++;
      check_eq({name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      check_eq({name, "_out_data"}, 32'(bus.out_data), 32'(dexp[31-8*idx -: 8]));
      if (aa) check_eq({name, "_drain_in_ready"}, 32'(bus.in_ready), 32'd0);
      if (bus.out_ready) idx++;
      @(negedge clk);
    end
    check_eq({name, "_drain_count"}, 32'(idx), 32'd4);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    check_eq({name, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    check_eq({name, "_idle_out_data"}, 32'(bus.out_data), 32'd0);
    check_eq({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_block("t1", 32'h30104020, 32'h10203040, 6, 0, 1'b0, 1'b0);
    run_block("t2", 32'h01020304, 32'h01020304, LEN_PRESORTED, 0, 1'b0, 1'b0);
    run_block("t3", 32'h808000FF, 32'h008080FF, 6, 0, 1'b0, 1'b1);
    run_block("t4", 32'h40302010, 32'h10203040, 6, 3, 1'b0, 1'b0);

    // Reset during the second SORT cycle
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h50 - 8'(k);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("t5_busy_sort", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t5_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_block("t5", 32'h04030201, 32'h01020304, 6, 0, 1'b0, 1'b0);

    run_block("t6", 32'h05070608, 32'h05060708, LEN_T6, 0, 1'b1, 1'b0);
    run_block("t6b", 32'hAA01AA02, 32'h0102AAAA, 6, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
